cpu_bus_sequencer: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 25 ++
 rtl/cpu_bus_script_ram.sv | 24 ++
 rtl/cpu_bus_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the 8227 bus sequencer: FSM state encoding and script entry layout.
package cpu_bus_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Default-width script entry; the sequencer rebuilds the same layout at its own widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] exp_addr;
    logic [ADDR_W_DEF-1:0] mask;
    logic                  nmi;
    logic                  irq;
    logic                  last;
  } script_entry_t;

  localparam int SCRIPT_ENTRY_W_DEF = $bits(script_entry_t);

endpackage

// File: rtl/cpu_bus_script_ram.sv
// Script storage: one synchronous write port, one asynchronous read port, no reset.
module cpu_bus_script_ram #(
  parameter int DEPTH   = 64,
  parameter int ENTRY_W = 43,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IDX_W-1:0]   ridx,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset so a script can be rerun after nrst.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Script-driven bus stimulus/checker for the 8227 core.
//
// state | meaning
// IDLE  | waiting for start, outputs held at 0, script writable
// RUN   | one script entry per clock: drive stimulus, compare address
// DONE  | script finished, results held, script writable
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_mask,
  input  logic              load_nmi,
  input  logic              load_irq,
  input  logic              load_last,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] dataBusInput,
  output logic              nonMaskableInterrupt,
  output logic              interruptRequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [IDX_W-1:0]  first_fail_step,
  output logic [IDX_W-1:0]  step
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] mask;
    logic              nmi;
    logic              irq;
    logic              last;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  seq_state_t         state;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic [ENTRY_W-1:0] rd_raw;
  logic               fail_seen;
  logic               addr_ok;
  logic               at_end;

  assign wr_entry = '{data: load_data, exp_addr: load_addr, mask: load_mask,
                      nmi: load_nmi, irq: load_irq, last: load_last};

  // Writes are blocked while running so the script under execution cannot change.
  cpu_bus_script_ram #(
    .DEPTH  (DEPTH),
    .ENTRY_W(ENTRY_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (load_en && (state != RUN)),
    .widx (load_idx),
    .wdata(wr_entry),
    .ridx (step),
    .rdata(rd_raw)
  );

  assign rd_entry = rd_raw;
  assign addr_ok  = ((addr_in ^ rd_entry.exp_addr) & rd_entry.mask) == '0;
  assign at_end   = rd_entry.last || (step == IDX_W'(DEPTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && !fail_seen;

  assign dataBusInput         = busy ? rd_entry.data : '0;
  assign nonMaskableInterrupt = busy && rd_entry.nmi;
  assign interruptRequest     = busy && rd_entry.irq;

  // Sequencer FSM with step counter and result tracking; abort wins over everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      step            <= '0;
      mismatch_count  <= '0;
      first_fail_step <= '0;
      fail_seen       <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            step            <= '0;
            mismatch_count  <= '0;
            first_fail_step <= '0;
            fail_seen       <= 1'b0;
          end
        end
        RUN: begin
          if (!addr_ok) begin
            if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
            if (!fail_seen) begin
              fail_seen       <= 1'b1;
              first_fail_step <= step;
            end
          end
          if (at_end) state <= DONE;
          else        step  <= step + IDX_W'(1);
        end
        default: begin
          state <= IDLE;
          step  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: default instance plus a DEPTH=4 / CNT_W=2 instance.
module tb_cpu_bus_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        load_en, load_en_s;
  logic [5:0]  load_idx;
  logic [1:0]  load_idx_s;
  logic [7:0]  load_data;
  logic [15:0] load_addr, load_mask;
  logic        load_nmi, load_irq, load_last;
  logic        start, start_s, abort;
  logic [15:0] addr_in;

  logic [7:0]  data_bus, data_bus_s;
  logic        nmi, irq, busy, done, pass;
  logic        nmi_s, irq_s, busy_s, done_s, pass_s;
  logic [7:0]  mcount;
  logic [5:0]  ffs, step;
  logic [1:0]  mcount_s, ffs_s, step_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_bus_sequencer u_dut (
    .clk(clk), .nrst(nrst),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .load_addr(load_addr), .load_mask(load_mask), .load_nmi(load_nmi),
    .load_irq(load_irq), .load_last(load_last),
    .start(start), .abort(abort), .addr_in(addr_in),
    .dataBusInput(data_bus), .nonMaskableInterrupt(nmi), .interruptRequest(irq),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mcount), .first_fail_step(ffs), .step(step)
  );

  cpu_bus_sequencer #(.DEPTH(4), .CNT_W(2)) u_small (
    .clk(clk), .nrst(nrst),
    .load_en(load_en_s), .load_idx(load_idx_s), .load_data(load_data),
    .load_addr(load_addr), .load_mask(load_mask), .load_nmi(load_nmi),
    .load_irq(load_irq), .load_last(load_last),
    .start(start_s), .abort(abort), .addr_in(addr_in),
    .dataBusInput(data_bus_s), .nonMaskableInterrupt(nmi_s), .interruptRequest(irq_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .mismatch_count(mcount_s), .first_fail_step(ffs_s), .step(step_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input logic [7:0] d, input logic [15:0] a, input logic [15:0] m,
                           input logic n, input logic i, input logic l);
    load_data = d; load_addr = a; load_mask = m;
    load_nmi = n; load_irq = i; load_last = l;
  endtask

  task automatic load(input logic [5:0] idx, input logic [7:0] d, input logic [15:0] a,
                      input logic [15:0] m, input logic n, input logic i, input logic l);
    set_entry(d, a, m, n, i, l);
    load_idx = idx; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_s(input logic [1:0] idx, input logic [7:0] d, input logic [15:0] a,
                        input logic [15:0] m);
    set_entry(d, a, m, 1'b0, 1'b0, 1'b0);
    load_idx_s = idx; load_en_s = 1'b1;
    @(negedge clk);
    load_en_s = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; load_en = 1'b0; load_en_s = 1'b0; load_idx = '0; load_idx_s = '0;
    set_entry(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    start = 1'b0; start_s = 1'b0; abort = 1'b0; addr_in = 16'h0000;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_step", 32'(step), 0);
    check("rst_count", 32'(mcount), 0);
    check("rst_ffs", 32'(ffs), 0);
    check("rst_data", 32'(data_bus), 0);
    check("rst_nmi", 32'(nmi), 0);
    check("rst_irq", 32'(irq), 0);
    nrst = 1'b1;
    @(negedge clk);

    // LDA zero page, all addresses correct
    load(6'd0, 8'hA5, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0);
    load(6'd1, 8'h99, 16'h0001, 16'hFF00, 1'b0, 1'b0, 1'b0);
    load(6'd2, 8'h42, 16'h0099, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    check("idle_data", 32'(data_bus), 0);
    pulse_start();
    check("lda_busy", 32'(busy), 1);
    check("lda_d0", 32'(data_bus), 32'hA5);
    addr_in = 16'h0000; @(negedge clk);
    check("lda_d1", 32'(data_bus), 32'h99);
    addr_in = 16'h0001; @(negedge clk);
    check("lda_d2", 32'(data_bus), 32'h42);
    check("lda_not_done", 32'(done), 0);
    addr_in = 16'h0099; @(negedge clk);
    check("lda_done", 32'(done), 1);
    check("lda_busy_off", 32'(busy), 0);
    check("lda_pass", 32'(pass), 1);
    check("lda_count", 32'(mcount), 0);
    check("lda_step_hold", 32'(step), 2);
    check("lda_done_data", 32'(data_bus), 0);

    // wrong address at step 2; masked-off bits at step 0; start during RUN ignored
    pulse_start();
    addr_in = 16'h0034; @(negedge clk);
    addr_in = 16'h0001; start = 1'b1; @(negedge clk);
    start = 1'b0;
    check("mm_step2", 32'(step), 2);
    addr_in = 16'h0098; @(negedge clk);
    check("mm_done", 32'(done), 1);
    check("mm_pass", 32'(pass), 0);
    check("mm_count", 32'(mcount), 1);
    check("mm_ffs", 32'(ffs), 2);

    // interrupt levels on step 1 only; load during RUN ignored
    load(6'd1, 8'h99, 16'h0001, 16'hFF00, 1'b1, 1'b1, 1'b0);
    pulse_start();
    check("int_s0_nmi", 32'(nmi), 0);
    check("int_s0_irq", 32'(irq), 0);
    addr_in = 16'h0000; @(negedge clk);
    check("int_s1_nmi", 32'(nmi), 1);
    check("int_s1_irq", 32'(irq), 1);
    set_entry(8'h77, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    load_idx = 6'd2; load_en = 1'b1;
    addr_in = 16'h0001; @(negedge clk);
    load_en = 1'b0;
    check("int_s2_data", 32'(data_bus), 32'h42);
    check("int_s2_nmi", 32'(nmi), 0);
    check("int_s2_irq", 32'(irq), 0);
    addr_in = 16'h0099; @(negedge clk);
    check("int_done", 32'(done), 1);
    check("int_pass", 32'(pass), 1);
    check("int_done_nmi", 32'(nmi), 0);

    // abort together with start at step 1
    pulse_start();
    addr_in = 16'h1234; @(negedge clk);
    check("ab_step1", 32'(step), 1);
    abort = 1'b1; start = 1'b1; @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_step", 32'(step), 0);
    check("ab_count_kept", 32'(mcount), 1);
    check("ab_ffs_kept", 32'(ffs), 0);
    check("ab_data", 32'(data_bus), 0);

    // failing run from IDLE, then restart from DONE
    pulse_start();
    addr_in = 16'h0000; @(negedge clk);
    addr_in = 16'h0100; @(negedge clk);
    addr_in = 16'h0099; @(negedge clk);
    check("f_pass", 32'(pass), 0);
    check("f_count", 32'(mcount), 1);
    check("f_ffs", 32'(ffs), 1);
    pulse_start();
    check("re_busy", 32'(busy), 1);
    check("re_count_clr", 32'(mcount), 0);
    check("re_ffs_clr", 32'(ffs), 0);
    check("re_step", 32'(step), 0);
    addr_in = 16'h0000; @(negedge clk);
    addr_in = 16'h0001; @(negedge clk);
    addr_in = 16'h0099; @(negedge clk);
    check("re_pass", 32'(pass), 1);

    // reset mid-RUN at step 3 of a 6-entry script
    for (int i = 0; i < 6; i++)
      load(6'(i), 8'(8'h10 + i), (i == 1) ? 16'hFFFF : 16'h0000,
           (i == 1) ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, i == 5);
    pulse_start();
    addr_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("mr_step3", 32'(step), 3);
    check("mr_data3", 32'(data_bus), 32'h13);
    check("mr_count_pre", 32'(mcount), 1);
    nrst = 1'b0; #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_step", 32'(step), 0);
    check("mr_data", 32'(data_bus), 0);
    check("mr_count", 32'(mcount), 0);
    check("mr_ffs", 32'(ffs), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    addr_in = 16'hFFFF;
    pulse_start();
    check("mr2_step0", 32'(step), 0);
    check("mr2_entry0", 32'(data_bus), 32'h10);
    repeat (6) @(negedge clk);
    check("mr2_done", 32'(done), 1);
    check("mr2_step_hold", 32'(step), 5);
    check("mr2_pass", 32'(pass), 1);

    // DEPTH=4, no last flags, every compare fails, 2-bit counter saturates
    for (int i = 0; i < 4; i++) load_s(2'(i), 8'(8'hC0 + i), 16'h0000, 16'hFFFF);
    addr_in = 16'hFFFF;
    start_s = 1'b1; @(negedge clk);
    start_s = 1'b0;
    check("sm_data0", 32'(data_bus_s), 32'hC0);
    repeat (3) @(negedge clk);
    check("sm_step3", 32'(step_s), 3);
    check("sm_busy3", 32'(busy_s), 1);
    check("sm_count3", 32'(mcount_s), 3);
    @(negedge clk);
    check("sm_done", 32'(done_s), 1);
    check("sm_step_hold", 32'(step_s), 3);
    check("sm_count_sat", 32'(mcount_s), 3);
    check("sm_ffs", 32'(ffs_s), 0);
    check("sm_pass", 32'(pass_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
